// File: rtl/checker_pkg.sv
// checker_pkg: shared state and fail-code definitions for mem_write_checker
package checker_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} chk_state_t;
  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_DATA    = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;
endpackage

// File: rtl/exp_table.sv
// exp_table: DEPTH-entry {addr,data} register file, sync write, all entries readable at once
// ports: clk, reset (sync, clears table), we/idx/addr/data write port, addr_o/data_o all entries
module exp_table #(
  parameter int N = 32,
  parameter int DEPTH = 4,
  parameter int IW = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [IW-1:0]             idx,
  input  logic [N-1:0]              addr,
  input  logic [N-1:0]              data,
  output logic [DEPTH-1:0][N-1:0]   addr_o,
  output logic [DEPTH-1:0][N-1:0]   data_o
);
  logic [DEPTH-1:0][N-1:0] addr_q, addr_d, data_q, data_d;
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (we) begin
      addr_d[idx] = addr;
      data_d[idx] = data;
    end
  end
  always_ff @(posedge clk) begin
    addr_q <= reset ? '0 : addr_d;
    data_q <= reset ? '0 : data_d;
  end
  assign addr_o = addr_q;
  assign data_o = data_q;
endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: watches a CPU data-memory write bus against a table of expected writes
// ports: clk, reset (sync); exp_we/exp_idx/exp_addr/exp_data table load; exp_count/ordered/start arm;
// memwrite/dataadr/writedata bus; busy/done/pass/fail/matched/fail_code/cycles status
module mem_write_checker
  import checker_pkg::*;
#(
  parameter int N = 32,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 1000,
  parameter int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          exp_we,
  input  logic [IW-1:0] exp_idx,
  input  logic [N-1:0]  exp_addr,
  input  logic [N-1:0]  exp_data,
  input  logic [IW:0]   exp_count,
  input  logic          ordered,
  input  logic          start,
  input  logic          memwrite,
  input  logic [N-1:0]  dataadr,
  input  logic [N-1:0]  writedata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [IW:0]   matched,
  output logic [1:0]    fail_code,
  output logic [N-1:0]  cycles
);
  chk_state_t state_q, state_d;
  logic [IW:0] matched_q, matched_d, cnt_q, cnt_d;
  logic [1:0] fc_q, fc_d;
  logic [N-1:0] cycles_q, cycles_d;
  logic ord_q, ord_d;
  logic [DEPTH-1:0] hit_q, hit_d;
  logic [DEPTH-1:0][N-1:0] t_addr, t_data;
  logic hit_found, hit_ok;
  logic [IW-1:0] hit_idx;
  exp_table #(.N(N), .DEPTH(DEPTH), .IW(IW)) u_table (
    .clk    (clk),
    .reset  (reset),
    .we     (exp_we && state_q == IDLE && int'(exp_idx) < DEPTH),
    .idx    (exp_idx),
    .addr   (exp_addr),
    .data   (exp_data),
    .addr_o (t_addr),
    .data_o (t_data)
  );
  // unordered search runs high-to-low so the lowest matching unhit index wins
  always_comb begin
    hit_found = 1'b0;
    hit_idx = matched_q[IW-1:0];
    if (ord_q) hit_found = memwrite && t_addr[matched_q[IW-1:0]] == dataadr;
    else
      for (int i = DEPTH - 1; i >= 0; i--)
        if (memwrite && i < int'(cnt_q) && !hit_q[i] && t_addr[i] == dataadr) begin
          hit_found = 1'b1;
          hit_idx = IW'(i);
        end
    hit_ok = hit_found && t_data[hit_idx] == writedata;
  end
  // a match outranks a same-cycle timeout
  always_comb begin
    state_d = state_q;
    matched_d = matched_q;
    cnt_d = cnt_q;
    fc_d = fc_q;
    cycles_d = cycles_q;
    ord_d = ord_q;
    hit_d = hit_q;
    if (start) begin
      state_d = exp_count == '0 ? PASS : RUN;
      cnt_d = exp_count;
      ord_d = ordered;
      matched_d = '0;
      hit_d = '0;
      cycles_d = '0;
      fc_d = FC_NONE;
    end else if (state_q == RUN) begin
      cycles_d = cycles_q + 1'b1;
      if (hit_found && !hit_ok) begin
        state_d = FAIL;
        fc_d = FC_DATA;
      end else if (hit_ok) begin
        matched_d = matched_q + 1'b1;
        hit_d[hit_idx] = 1'b1;
        state_d = matched_d == cnt_q ? PASS : RUN;
      end else if (cycles_q == N'(TIMEOUT - 1)) begin
        state_d = FAIL;
        fc_d = FC_TIMEOUT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      matched_q <= '0;
      cnt_q <= '0;
      fc_q <= FC_NONE;
      cycles_q <= '0;
      ord_q <= 1'b0;
      hit_q <= '0;
    end else begin
      state_q <= state_d;
      matched_q <= matched_d;
      cnt_q <= cnt_d;
      fc_q <= fc_d;
      cycles_q <= cycles_d;
      ord_q <= ord_d;
      hit_q <= hit_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == PASS || state_q == FAIL;
  assign pass = state_q == PASS;
  assign fail = state_q == FAIL;
  assign matched = matched_q;
  assign fail_code = fc_q;
  assign cycles = cycles_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed vector table plus timeout/reset sequences for mem_write_checker
module tb_mem_write_checker;
  logic clk = 1'b0;
  logic reset, exp_we, ordered, start, memwrite;
  logic [1:0] exp_idx;
  logic [31:0] exp_addr, exp_data, dataadr, writedata;
  logic [2:0] exp_count;
  logic busy, done, pass, fail;
  logic [2:0] matched;
  logic [1:0] fail_code;
  logic [31:0] cycles;
  int unsigned tests = 0, fails = 0;
  always #5 clk = ~clk;
  mem_write_checker #(.N(32), .DEPTH(4), .TIMEOUT(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .exp_we    (exp_we),
    .exp_idx   (exp_idx),
    .exp_addr  (exp_addr),
    .exp_data  (exp_data),
    .exp_count (exp_count),
    .ordered   (ordered),
    .start     (start),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .matched   (matched),
    .fail_code (fail_code),
    .cycles    (cycles)
  );
  typedef struct {
    logic rst, we;
    logic [1:0] idx;
    logic [31:0] addr, data;
    logic [2:0] cnt;
    logic ord, st, mw;
    logic [31:0] adr, wd;
    logic e_busy, e_done, e_pass, e_fail;
    logic [2:0] e_m;
    logic [1:0] e_fc;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic idle_in();
    reset = 0; exp_we = 0; exp_idx = 0; exp_addr = 0; exp_data = 0; exp_count = 0;
    ordered = 0; start = 0; memwrite = 0; dataadr = 0; writedata = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    idle_in();
  endtask
  task automatic status(input string nm, input logic b, input logic d, input logic p, input logic f,
                        input logic [2:0] m, input logic [1:0] fc);
    chk({nm, " busy"}, 32'(busy), 32'(b));
    chk({nm, " done"}, 32'(done), 32'(d));
    chk({nm, " pass"}, 32'(pass), 32'(p));
    chk({nm, " fail"}, 32'(fail), 32'(f));
    chk({nm, " matched"}, 32'(matched), 32'(m));
    chk({nm, " fail_code"}, 32'(fail_code), 32'(fc));
  endtask
  task automatic load(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d);
    exp_we = 1; exp_idx = i; exp_addr = a; exp_data = d;
    tick();
  endtask
  task automatic arm(input logic [2:0] c, input logic o);
    start = 1; exp_count = c; ordered = o;
    tick();
  endtask
  task automatic bus(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1; dataadr = a; writedata = d;
    tick();
  endtask
  initial begin
    v.push_back('{0,1,0,84,'h96,0,0,0,0,0,0,      0,0,0,0,0,0});
    v.push_back('{0,0,0,0,0,1,1,1,0,0,0,          1,0,0,0,0,0});
    v.push_back('{0,0,0,0,0,0,0,0,1,84,'h96,      0,1,1,0,1,0});
    v.push_back('{1,0,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0});
    v.push_back('{0,1,0,80,5,0,0,0,0,0,0,         0,0,0,0,0,0});
    v.push_back('{0,1,1,84,7,0,0,0,0,0,0,         0,0,0,0,0,0});
    v.push_back('{0,0,0,0,0,2,1,1,0,0,0,          1,0,0,0,0,0});
    v.push_back('{0,0,0,0,0,0,0,0,1,84,7,         1,0,0,0,0,0});
    v.push_back('{0,0,0,0,0,0,0,0,1,80,5,         1,0,0,0,1,0});
    v.push_back('{0,0,0,0,0,0,0,0,1,84,7,         0,1,1,0,2,0});
    v.push_back('{0,0,0,0,0,2,0,1,0,0,0,          1,0,0,0,0,0});
    v.push_back('{0,0,0,0,0,0,0,0,1,84,7,         1,0,0,0,1,0});
    v.push_back('{0,0,0,0,0,0,0,0,1,84,7,         1,0,0,0,1,0});
    v.push_back('{0,0,0,0,0,0,0,0,0,80,5,         1,0,0,0,1,0});
    v.push_back('{0,0,0,0,0,0,0,0,1,80,5,         0,1,1,0,2,0});
    v.push_back('{0,0,0,0,0,2,0,1,0,0,0,          1,0,0,0,0,0});
    v.push_back('{0,0,0,0,0,0,0,0,1,80,6,         0,1,0,1,0,1});
    v.push_back('{0,0,0,0,0,0,0,0,0,0,0,          0,1,0,1,0,1});
    v.push_back('{0,0,0,0,0,0,0,1,0,0,0,          0,1,1,0,0,0});
    v.push_back('{0,0,0,0,0,2,1,1,0,0,0,          1,0,0,0,0,0});
    v.push_back('{0,0,0,0,0,0,0,0,1,80,9,         0,1,0,1,0,1});
    v.push_back('{1,0,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0});
    v.push_back('{0,1,0,88,1,0,0,0,0,0,0,         0,0,0,0,0,0});
    v.push_back('{0,1,1,88,1,0,0,0,0,0,0,         0,0,0,0,0,0});
    v.push_back('{0,0,0,0,0,2,0,1,0,0,0,          1,0,0,0,0,0});
    v.push_back('{0,0,0,0,0,0,0,0,1,88,1,         1,0,0,0,1,0});
    v.push_back('{0,0,0,0,0,0,0,0,1,88,1,         0,1,1,0,2,0});
    idle_in();
    reset = 1;
    tick();
    status("reset", 0, 0, 0, 0, 0, 0);
    chk("reset cycles", cycles, 0);
    foreach (v[i]) begin
      reset = v[i].rst; exp_we = v[i].we; exp_idx = v[i].idx; exp_addr = v[i].addr;
      exp_data = v[i].data; exp_count = v[i].cnt; ordered = v[i].ord; start = v[i].st;
      memwrite = v[i].mw; dataadr = v[i].adr; writedata = v[i].wd;
      tick();
      status($sformatf("vec%0d", i), v[i].e_busy, v[i].e_done, v[i].e_pass, v[i].e_fail, v[i].e_m, v[i].e_fc);
    end
    reset = 1;
    tick();
    load(0, 100, 1);
    arm(1, 1);
    chk("to start cycles", cycles, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("to fail@%0d", k), 32'(fail), 32'(k == 10));
      chk($sformatf("to cycles@%0d", k), cycles, k);
    end
    chk("to fail_code", 32'(fail_code), 2);
    repeat (3) tick();
    chk("to frozen cycles", cycles, 10);
    chk("to sticky fail", 32'(fail), 1);
    arm(1, 1);
    repeat (9) tick();
    chk("race cycles", cycles, 9);
    bus(100, 1);
    status("race", 0, 1, 1, 0, 1, 0);
    chk("race cycles end", cycles, 10);
    reset = 1;
    tick();
    load(0, 80, 5);
    load(1, 84, 7);
    arm(2, 1);
    bus(80, 5);
    status("mid run", 1, 0, 0, 0, 1, 0);
    reset = 1;
    tick();
    status("mid reset", 0, 0, 0, 0, 0, 0);
    chk("mid reset cycles", cycles, 0);
    arm(1, 1);
    bus(0, 0);
    status("zeroed table", 0, 1, 1, 0, 1, 0);
    reset = 1;
    tick();
    load(0, 80, 5);
    load(1, 84, 7);
    arm(2, 1);
    bus(80, 5);
    bus(84, 7);
    status("reload", 0, 1, 1, 0, 2, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
